// File: rtl/rv_id_stage_pkg.sv
// Shared RV32I decode constants and the decode-to-execute bundle type.
// Opcode and ALU-op encodings are common to the decode and execute stages.
// The ALU opcode is {funct7[5], funct3}, and ADD is all zeros.
package rv_id_stage_pkg;

  localparam int BUS_W = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // Registered payload handed to execute.
  typedef struct packed {
    logic [3:0]       alu_op;
    logic [BUS_W-1:0] src_a;
    logic [BUS_W-1:0] src_b;
    logic [BUS_W-1:0] store_data;
    logic [BUS_W-1:0] pc;
    logic [4:0]       rd;
    logic             we;
    logic             mem_rd;
    logic             mem_wr;
    logic             branch;
    logic             jump;
    logic [2:0]       funct3;
    logic             illegal;
  } id_bundle_t;

endpackage

// File: rtl/rv_id_stage_imm.sv
// Immediate generator: builds the sign-extended RV32I immediate for the opcode.
// Latency: combinational.
// Backpressure: none, this block is pure logic.
import rv_id_stage_pkg::*;

module rv_id_stage_imm (
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  logic [6:0] opc;
  logic [2:0] f3;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];

  // Pick the immediate layout for the opcode. Shift-immediates carry funct7
  // in imm[11:5], so only the shamt is passed on as the operand.
  always_comb begin
    imm = '0;
    case (opc)
      OP_IMM: begin
        if (f3 == 3'b001 || f3 == 3'b101) imm = {27'd0, instr[24:20]};
        else                              imm = {{20{instr[31]}}, instr[31:20]};
      end
      OP_LOAD, OP_JALR: imm = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_JAL:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      OP_LUI, OP_AUIPC: imm = {instr[31:12], 12'd0};
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/rv_id_stage.sv
// RV32I decode stage: decodes one instruction and registers the execute bundle.
// Latency: one cycle from capture to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; the bundle holds while stalled.
import rv_id_stage_pkg::*;

module rv_id_stage (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [BUS_W-1:0] in_pc,
  output logic [4:0]       rf_raddr1,
  output logic [4:0]       rf_raddr2,
  input  logic [BUS_W-1:0] rf_rdata1,
  input  logic [BUS_W-1:0] rf_rdata2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_aluOp,
  output logic [BUS_W-1:0] out_srcA,
  output logic [BUS_W-1:0] out_srcB,
  output logic [BUS_W-1:0] out_storeData,
  output logic [BUS_W-1:0] out_pc,
  output logic [4:0]       out_rd,
  output logic             out_we,
  output logic             out_memRd,
  output logic             out_memWr,
  output logic             out_branch,
  output logic             out_jump,
  output logic [2:0]       out_funct3,
  output logic             out_illegal
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm;
  logic        legal;
  logic        wb;
  logic        capture;
  id_bundle_t  nb;
  id_bundle_t  bq;
  logic        vld_q;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  assign rf_raddr1 = in_instr[19:15];
  assign rf_raddr2 = in_instr[24:20];

  assign in_ready = !vld_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  rv_id_stage_imm u_imm (
    .instr (in_instr),
    .imm   (imm)
  );

  // Decode the incoming instruction into the next bundle value.
  always_comb begin
    nb            = '0;
    legal         = 1'b1;
    wb            = 1'b0;
    nb.pc         = in_pc;
    nb.rd         = in_instr[11:7];
    nb.funct3     = f3;
    nb.store_data = rf_rdata2;
    nb.alu_op     = ALU_ADD;
    case (opc)
      OP_OP: begin
        nb.alu_op = {in_instr[30], f3};
        nb.src_a  = rf_rdata1;
        nb.src_b  = rf_rdata2;
        wb        = 1'b1;
        if (f7 == F7_ALT)       legal = (f3 == 3'b000) || (f3 == 3'b101);
        else if (f7 != F7_BASE) legal = 1'b0;
      end
      OP_IMM: begin
        nb.alu_op = (f3 == 3'b101) ? {in_instr[30], f3} : {1'b0, f3};
        nb.src_a  = rf_rdata1;
        nb.src_b  = imm;
        wb        = 1'b1;
        if (f3 == 3'b001)      legal = (f7 == F7_BASE);
        else if (f3 == 3'b101) legal = (f7 == F7_BASE) || (f7 == F7_ALT);
      end
      OP_LOAD: begin
        nb.src_a  = rf_rdata1;
        nb.src_b  = imm;
        nb.mem_rd = 1'b1;
        wb        = 1'b1;
      end
      OP_JALR: begin
        nb.src_a = rf_rdata1;
        nb.src_b = imm;
        nb.jump  = 1'b1;
        wb       = 1'b1;
      end
      OP_STORE: begin
        nb.src_a  = rf_rdata1;
        nb.src_b  = imm;
        nb.mem_wr = 1'b1;
      end
      OP_BRANCH: begin
        nb.src_a  = in_pc;
        nb.src_b  = imm;
        nb.branch = 1'b1;
      end
      OP_JAL: begin
        nb.src_a = in_pc;
        nb.src_b = imm;
        nb.jump  = 1'b1;
        wb       = 1'b1;
      end
      OP_LUI: begin
        nb.src_b = imm;
        wb       = 1'b1;
      end
      OP_AUIPC: begin
        nb.src_a = in_pc;
        nb.src_b = imm;
        wb       = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    nb.illegal = !legal;
    nb.we      = wb && legal && (in_instr[11:7] != 5'd0);
    if (!legal) begin
      nb.mem_rd = 1'b0;
      nb.mem_wr = 1'b0;
      nb.branch = 1'b0;
      nb.jump   = 1'b0;
    end
  end

  // Pipeline register: valid follows reset > flush > capture > drain; payload loads only on capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      bq    <= '0;
    end else begin
      if (flush)          vld_q <= 1'b0;
      else if (capture)   vld_q <= 1'b1;
      else if (out_ready) vld_q <= 1'b0;
      if (capture) bq <= nb;
    end
  end

  assign out_valid     = vld_q;
  assign out_aluOp     = bq.alu_op;
  assign out_srcA      = bq.src_a;
  assign out_srcB      = bq.src_b;
  assign out_storeData = bq.store_data;
  assign out_pc        = bq.pc;
  assign out_rd        = bq.rd;
  assign out_we        = bq.we;
  assign out_memRd     = bq.mem_rd;
  assign out_memWr     = bq.mem_wr;
  assign out_branch    = bq.branch;
  assign out_jump      = bq.jump;
  assign out_funct3    = bq.funct3;
  assign out_illegal   = bq.illegal;

endmodule

// File: tb/tb_rv_id_stage.sv
// Bench for rv_id_stage: directed and random instructions against a reference decoder.
// Latency: expected bundles are queued at capture and matched while out_valid is high.
// Backpressure: random out_ready stalls, flushes and resets exercise the handshake.
import rv_id_stage_pkg::*;

module tb_rv_id_stage;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [BUS_W-1:0] in_pc;
  logic [4:0]       rf_raddr1, rf_raddr2;
  logic [BUS_W-1:0] rf_rdata1, rf_rdata2;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_aluOp;
  logic [BUS_W-1:0] out_srcA, out_srcB, out_storeData, out_pc;
  logic [4:0]       out_rd;
  logic             out_we, out_memRd, out_memWr, out_branch, out_jump;
  logic [2:0]       out_funct3;
  logic             out_illegal;

  typedef struct packed {
    id_bundle_t exp;
    id_bundle_t care;
  } sb_entry_t;

  sb_entry_t sbq[$];
  bit        mv = 1'b0;
  bit        mon_en = 1'b0;
  int        total = 0;
  int        bad = 0;

  always #5 clk = ~clk;

  rv_id_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_aluOp(out_aluOp),
    .out_srcA(out_srcA), .out_srcB(out_srcB), .out_storeData(out_storeData),
    .out_pc(out_pc), .out_rd(out_rd), .out_we(out_we), .out_memRd(out_memRd),
    .out_memWr(out_memWr), .out_branch(out_branch), .out_jump(out_jump),
    .out_funct3(out_funct3), .out_illegal(out_illegal)
  );

  // Reference decoder written from the instruction-set rules with integer arithmetic.
  function automatic sb_entry_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                           input logic [31:0] r1, input logic [31:0] r2);
    sb_entry_t  s;
    logic [6:0] opc = ins[6:0];
    logic [6:0] f7  = ins[31:25];
    logic [2:0] f3  = ins[14:12];
    int imm_i = int'($signed(ins[31:20]));
    int imm_s = int'($signed({ins[31:25], ins[11:7]}));
    int imm_b = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    int imm_j = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    int imm_u = int'({ins[31:12], 12'd0});
    int shamt = int'(ins[24:20]);
    bit ok = 1'b1;
    bit writes = 1'b0;
    bit known = 1'b1;
    s.exp = '0;
    s.care = '1;
    s.exp.pc = pc;
    s.exp.rd = ins[11:7];
    s.exp.funct3 = f3;
    s.exp.store_data = r2;
    case (opc)
      7'h33: begin
        s.exp.alu_op = {ins[30], f3};
        s.exp.src_a = r1; s.exp.src_b = r2; writes = 1;
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'h13: begin
        s.exp.alu_op = (f3 == 3'd5) ? {ins[30], f3} : {1'b0, f3};
        s.exp.src_a = r1; writes = 1;
        if (f3 == 3'd1) begin s.exp.src_b = shamt; ok = (f7 == 7'h00); end
        else if (f3 == 3'd5) begin s.exp.src_b = shamt; ok = (f7 == 7'h00 || f7 == 7'h20); end
        else s.exp.src_b = imm_i;
      end
      7'h03: begin s.exp.src_a = r1; s.exp.src_b = imm_i; s.exp.mem_rd = 1; writes = 1; end
      7'h67: begin s.exp.src_a = r1; s.exp.src_b = imm_i; s.exp.jump = 1; writes = 1; end
      7'h23: begin s.exp.src_a = r1; s.exp.src_b = imm_s; s.exp.mem_wr = 1; end
      7'h63: begin s.exp.src_a = pc; s.exp.src_b = imm_b; s.exp.branch = 1; end
      7'h6F: begin s.exp.src_a = pc; s.exp.src_b = imm_j; s.exp.jump = 1; writes = 1; end
      7'h37: begin s.exp.src_a = 0;  s.exp.src_b = imm_u; writes = 1; end
      7'h17: begin s.exp.src_a = pc; s.exp.src_b = imm_u; writes = 1; end
      default: begin ok = 0; known = 0; end
    endcase
    s.exp.illegal = !ok;
    s.exp.we = writes && ok && (ins[11:7] != 5'd0);
    if (!ok) begin
      s.exp.mem_rd = 0; s.exp.mem_wr = 0; s.exp.branch = 0; s.exp.jump = 0;
    end
    if (opc != 7'h23) s.care.store_data = '0;
    if (!writes) s.care.rd = '0;
    if (!known) begin s.care.src_a = '0; s.care.src_b = '0; end
    return s;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 9);
    int sel = $urandom_range(0, 3);
    if (k < 9) w[6:0] = ops[k];
    if (w[6:0] == 7'h33 || (w[6:0] == 7'h13 && (w[14:12] == 3'd1 || w[14:12] == 3'd5))) begin
      if (sel == 0) w[31:25] = 7'h00;
      else if (sel == 1) w[31:25] = 7'h20;
    end
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  // Drive one cycle of stimulus on the falling edge and advance the reference state.
  task automatic step(input bit rst, input bit vld, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2, input bit ordy, input bit fl);
    bit rdy;
    @(negedge clk);
    rst_n = rst; in_valid = vld; in_instr = ins; in_pc = pc;
    rf_rdata1 = r1; rf_rdata2 = r2; out_ready = ordy; flush = fl;
    #2;
    rdy = !mv || ordy;
    if (!rst || fl) begin
      mv = 0;
      sbq.delete();
    end else if (vld && rdy) begin
      sbq.push_back(ref_decode(ins, pc, r1, r2));
      mv = 1;
    end else if (ordy) begin
      mv = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    logic [200:0] all;
    all = {out_valid, out_aluOp, out_srcA, out_srcB, out_storeData, out_pc, out_rd, out_we,
           out_memRd, out_memWr, out_branch, out_jump, out_funct3, out_illegal};
    total++;
    if (all !== '0) begin
      bad++;
      $display("FAIL %s: outputs %h expected all zero", name, all);
    end
  endtask

  // Monitor: check handshake signals every cycle and match the presented bundle.
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      id_bundle_t act;
      total++;
      if (out_valid !== mv) begin
        bad++; $display("FAIL out_valid: got %b expected %b", out_valid, mv);
      end
      total++;
      if (in_ready !== (!mv || out_ready)) begin
        bad++; $display("FAIL in_ready: got %b expected %b", in_ready, !mv || out_ready);
      end
      total++;
      if ({rf_raddr1, rf_raddr2} !== {in_instr[19:15], in_instr[24:20]}) begin
        bad++; $display("FAIL rf_raddr: got %h/%h expected %h/%h", rf_raddr1, rf_raddr2,
                        in_instr[19:15], in_instr[24:20]);
      end
      if (out_valid === 1'b1) begin
        act.alu_op = out_aluOp; act.src_a = out_srcA; act.src_b = out_srcB;
        act.store_data = out_storeData; act.pc = out_pc; act.rd = out_rd; act.we = out_we;
        act.mem_rd = out_memRd; act.mem_wr = out_memWr; act.branch = out_branch;
        act.jump = out_jump; act.funct3 = out_funct3; act.illegal = out_illegal;
        total++;
        if (sbq.size() == 0) begin
          bad++; $display("FAIL bundle: got %h expected no valid bundle", act);
        end else begin
          if (((act ^ sbq[0].exp) & sbq[0].care) !== '0) begin
            bad++;
            $display("FAIL bundle: got %h expected %h care %h", act, sbq[0].exp, sbq[0].care);
          end
          if (out_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] sw_i, beq_i, addi0_i, pc;
    sw_i    = {7'h7F, 5'd2, 5'd1, 3'b010, 5'h1C, 7'h23};
    beq_i   = {1'b0, 6'd0, 5'd2, 5'd1, 3'b000, 4'b0100, 1'b0, 7'h63};
    addi0_i = {12'd1, 5'd0, 3'b000, 5'd0, 7'h13};
    rst_n = 0; in_valid = 0; in_instr = 0; in_pc = 0; rf_rdata1 = 0; rf_rdata2 = 0;
    flush = 0; out_ready = 0;

    repeat (2) step(0, 1, 32'h002081B3, 32'h40, 5, 7, 1, 0);
    @(posedge clk); #1;
    check_zero("reset_state");
    mon_en = 1;

    step(1, 1, 32'h002081B3, 32'h0, 5, 7, 1, 0);
    @(posedge clk); #1;
    chk("add_aluop", {28'd0, out_aluOp}, 32'h0);
    chk("add_srcA", out_srcA, 5);
    chk("add_srcB", out_srcB, 7);
    chk("add_rd_we", {out_rd, out_we}, {5'd3, 1'b1});

    step(1, 1, 32'h4030D293, 32'h4, 20, 0, 1, 0);
    @(posedge clk); #1;
    chk("srai", {out_aluOp, out_srcB}, {4'b1101, 32'd3});
    step(1, 1, 32'h40110233, 32'h8, 9, 4, 1, 0);
    @(posedge clk); #1;
    chk("sub_aluop", {28'd0, out_aluOp}, 32'h8);

    step(1, 1, sw_i, 32'hC, 32'h1000, 32'hABCD, 1, 0);
    @(posedge clk); #1;
    chk("sw_srcB", out_srcB, 32'hFFFFFFFC);
    chk("sw_memwr", {31'd0, out_memWr}, 1);
    step(1, 1, beq_i, 32'h100, 3, 3, 1, 0);
    @(posedge clk); #1;
    chk("beq", {out_srcA, out_srcB, out_branch}, {32'h100, 32'd8, 1'b1});

    step(1, 1, 32'h0000007F, 32'h104, 1, 2, 1, 0);
    @(posedge clk); #1;
    chk("illegal_7f", {out_illegal, out_we}, {1'b1, 1'b0});
    step(1, 1, addi0_i, 32'h108, 1, 2, 1, 0);
    @(posedge clk); #1;
    chk("addi_x0", {out_illegal, out_we}, {1'b0, 1'b0});

    // Stall three cycles with a waiting instruction, then release.
    step(1, 1, 32'h00412083, 32'h200, 32'h50, 0, 1, 0);
    repeat (3) step(1, 1, 32'h002081B3, 32'h204, 11, 12, 0, 0);
    step(1, 1, 32'h002081B3, 32'h204, 11, 12, 1, 0);
    @(posedge clk); #1;
    chk("after_stall", out_srcA + out_srcB, 23);

    // Flush coincident with in_valid; flush of a held bundle.
    step(1, 1, 32'h002081B3, 32'h300, 1, 1, 1, 1);
    step(1, 1, 32'h002081B3, 32'h304, 1, 1, 0, 0);
    step(1, 0, 32'h0, 32'h0, 0, 0, 0, 1);
    step(1, 0, 32'h0, 32'h0, 0, 0, 1, 0);

    // Reset while a bundle is stalled.
    step(1, 1, 32'h00500313, 32'h400, 1, 1, 1, 0);
    step(1, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    step(0, 1, 32'h002081B3, 32'h404, 1, 1, 0, 0);
    @(posedge clk); #1;
    check_zero("reset_mid_stall");

    pc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), rand_instr(), pc,
           $urandom, $urandom, ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
      pc = pc + 4;
    end
    step(1, 0, 32'h0, 32'h0, 0, 0, 1, 0);
    step(1, 0, 32'h0, 32'h0, 0, 0, 1, 0);
    @(negedge clk); #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
